tape_framer: RTL and testbench

Byte-stream framer sitting directly upstream of the `video_out` stage in the datatape path. Accepts raw payload bytes from the host side (Ethernet receive logic, same clock domain), buffers them in an internal FIFO, and emits a continuous sequence of fixed-length frames. Each frame carries sync, sequence number, length, payload and CRC bytes, presented on the `data_out` / `data_out_ready` pair consumed by `video_out`. When no host data is pending, the block emits empty frames, so the output stream never stalls.

---
 rtl/tape_framer.sv | 160 ++++++++++++++++
 tb/tb_tape_framer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tape_framer.sv
// Datatape framer: buffers host bytes in a FIFO and emits back-to-back fixed-length
// frames (SYNC0 SYNC1 SEQ LEN payload [CRC]). Define TAPE_FRAMER_CRC_EN to append a CRC-8 byte.
module tape_framer #(
   parameter int PAYLOAD_BYTES = 240,
   parameter int FIFO_DEPTH    = 512
) (
   input  logic                        clk_ntsc,
   input  logic                        rst,
   input  logic [7:0]                  in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        output_ready,
   output logic [7:0]                  data_out,
   output logic                        data_out_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [7:0]                  seq_num
);
   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_LVL = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] PAY_LVL   = (AW+1)'(PAYLOAD_BYTES);
   localparam logic [7:0]  LAST_IDX  = 8'(PAYLOAD_BYTES - 1);
   localparam logic [7:0]  SYNC0     = 8'hA5;
   localparam logic [7:0]  SYNC1     = 8'h5A;

   typedef enum logic [2:0] {
      S_SYNC0, S_SYNC1, S_SEQ, S_LEN, S_PAY
`ifdef TAPE_FRAMER_CRC_EN
      , S_CRC
`endif
   } state_t;

   state_t        state, state_n;
   logic [7:0]    byte_n, len_q, len_n, pay_idx, idx_n, seq_n;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   lvl_cap;
   logic          push, pop;

`ifdef TAPE_FRAMER_CRC_EN
   logic [7:0] crc_q, crc_n;

   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
      logic [7:0] c;
      c = crc ^ d;
      for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      return c;
   endfunction
`endif

   assign in_ready = !rst && (fifo_level < DEPTH_LVL);
   assign push     = in_valid && in_ready;
   assign lvl_cap  = (fifo_level > PAY_LVL) ? PAY_LVL : fifo_level;

   // Next-state / next-byte logic; the byte for the next state is loaded on each transfer.
   always_comb begin
      state_n = state;
      byte_n  = data_out;
      len_n   = len_q;
      idx_n   = pay_idx;
      seq_n   = seq_num;
      pop     = 1'b0;
`ifdef TAPE_FRAMER_CRC_EN
      crc_n   = crc_q;
`endif
      if (!data_out_ready) begin
         byte_n = SYNC0;
      end else if (output_ready) begin
         case (state)
            S_SYNC0: begin
               state_n = S_SYNC1;
               byte_n  = SYNC1;
            end
            S_SYNC1: begin
               state_n = S_SEQ;
               byte_n  = seq_num;
            end
            S_SEQ: begin
               state_n = S_LEN;
               len_n   = 8'(lvl_cap);
               byte_n  = len_n;
`ifdef TAPE_FRAMER_CRC_EN
               crc_n   = crc8_byte(8'h00, data_out);
`endif
            end
            S_LEN: begin
               state_n = S_PAY;
               idx_n   = 8'h00;
               pop     = (len_q != 8'h00);
               byte_n  = pop ? mem[rd_ptr] : 8'h00;
`ifdef TAPE_FRAMER_CRC_EN
               crc_n   = crc8_byte(crc_q, data_out);
`endif
            end
            S_PAY: begin
`ifdef TAPE_FRAMER_CRC_EN
               crc_n = crc8_byte(crc_q, data_out);
`endif
               if (pay_idx == LAST_IDX) begin
`ifdef TAPE_FRAMER_CRC_EN
                  state_n = S_CRC;
                  byte_n  = crc_n;
`else
                  state_n = S_SYNC0;
                  byte_n  = SYNC0;
                  seq_n   = seq_num + 8'd1;
`endif
               end else begin
                  idx_n  = pay_idx + 8'd1;
                  pop    = (idx_n < len_q);
                  byte_n = pop ? mem[rd_ptr] : 8'h00;
               end
            end
`ifdef TAPE_FRAMER_CRC_EN
            S_CRC: begin
               state_n = S_SYNC0;
               byte_n  = SYNC0;
               seq_n   = seq_num + 8'd1;
            end
`endif
            default: state_n = S_SYNC0;
         endcase
      end
   end

   always_ff @(posedge clk_ntsc) begin
      if (rst) begin
         state          <= S_SYNC0;
         data_out       <= 8'h00;
         data_out_ready <= 1'b0;
         seq_num        <= 8'h00;
         len_q          <= 8'h00;
         pay_idx        <= 8'h00;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fifo_level     <= '0;
`ifdef TAPE_FRAMER_CRC_EN
         crc_q          <= 8'h00;
`endif
      end else begin
         state          <= state_n;
         data_out       <= byte_n;
         data_out_ready <= 1'b1;
         seq_num        <= seq_n;
         len_q          <= len_n;
         pay_idx        <= idx_n;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         fifo_level     <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
`ifdef TAPE_FRAMER_CRC_EN
         crc_q          <= crc_n;
`endif
      end
   end

   // Storage needs no reset; pointers and level define what is valid.
   always_ff @(posedge clk_ntsc) begin
      if (push) mem[wr_ptr] <= in_data;
   end

endmodule

// File: tb/tb_tape_framer.sv
// Directed bench for tape_framer (PAYLOAD_BYTES=4, FIFO_DEPTH=8); follows TAPE_FRAMER_CRC_EN.
module tb_tape_framer;
   localparam int P = 4;
`ifdef TAPE_FRAMER_CRC_EN
   localparam int FL = P + 5;
`else
   localparam int FL = P + 4;
`endif

   logic       clk_ntsc = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       output_ready = 1'b0;
   logic [7:0] data_out;
   logic       data_out_ready;
   logic [3:0] fifo_level;
   logic [7:0] seq_num;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   logic [7:0] ef [0:8];
   logic [7:0] model_q [$];
   logic [7:0] stream [$];

   tape_framer #(.PAYLOAD_BYTES(P), .FIFO_DEPTH(8)) dut (
      .clk_ntsc(clk_ntsc), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .output_ready(output_ready), .data_out(data_out),
      .data_out_ready(data_out_ready), .fifo_level(fifo_level), .seq_num(seq_num)
   );

   always #5 clk_ntsc = ~clk_ntsc;

   task automatic step();
      @(posedge clk_ntsc);
      #1;
   endtask

   // Bit-serial CRC-8 (poly 0x07, init 0, MSB first)
   function automatic logic [7:0] crc_model(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] r;
      logic       fb;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         fb = r[7] ^ d[i];
         r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return r;
   endfunction

   task automatic build_frame(input logic [7:0] seq, input int len);
      logic [7:0] c;
      ef[0] = 8'hA5; ef[1] = 8'h5A; ef[2] = seq; ef[3] = 8'(len);
      for (int i = 0; i < P; i++) ef[4+i] = (i < len) ? model_q.pop_front() : 8'h00;
      c = 8'h00;
      for (int i = 2; i < P + 4; i++) c = crc_model(c, ef[i]);
      ef[8] = c;
   endtask

   task automatic xfer(output logic [7:0] b, output logic v);
      b = data_out;
      v = data_out_ready;
      output_ready = 1'b1;
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; output_ready = 1'b0;
      step();
      rst = 1'b0;
      step();
      model_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      chk_cnt++; if (data_out_ready !== 1'b0) $display("FAIL rst_dor got %b want 0", data_out_ready); else pass_cnt++;
      chk_cnt++; if (data_out !== 8'h00) $display("FAIL rst_data got %h want 00", data_out); else pass_cnt++;
      chk_cnt++; if (fifo_level !== 4'd0) $display("FAIL rst_level got %0d want 0", fifo_level); else pass_cnt++;
      chk_cnt++; if (seq_num !== 8'h00) $display("FAIL rst_seq got %h want 00", seq_num); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else pass_cnt++;
      rst = 1'b0;
      step();
      chk_cnt++; if (data_out_ready !== 1'b1) $display("FAIL rel_dor got %b want 1", data_out_ready); else pass_cnt++;
      chk_cnt++; if (data_out !== 8'hA5) $display("FAIL rel_data got %h want a5", data_out); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready got %b want 1", in_ready); else pass_cnt++;
   endtask

   task automatic test_empty();
      logic [7:0] b;
      logic       v;
      do_reset();
      for (int f = 0; f < 2; f++) begin
         build_frame(8'(f), 0);
         for (int i = 0; i < FL; i++) begin
            xfer(b, v);
            chk_cnt++;
            if (b !== ef[i] || v !== 1'b1) $display("FAIL empty_f%0d_b%0d got %h/%b want %h/1", f, i, b, v, ef[i]);
            else pass_cnt++;
         end
      end
`ifdef TAPE_FRAMER_CRC_EN
      chk_cnt++; if (ef[8] !== 8'h29) $display("FAIL empty_crc1_ref got %h want 29", ef[8]); else pass_cnt++;
`endif
      // SYNC0 must follow the last byte of a frame with no gap
      chk_cnt++; if (data_out !== 8'hA5) $display("FAIL empty_next_sync got %h want a5", data_out); else pass_cnt++;
      chk_cnt++; if (seq_num !== 8'h02) $display("FAIL empty_seq got %h want 02", seq_num); else pass_cnt++;
   endtask

   task automatic test_partial();
      logic [7:0] b;
      logic       v;
      do_reset();
      in_valid = 1'b1; in_data = 8'h11; model_q.push_back(8'h11);
      xfer(b, v);
      in_data = 8'h22; model_q.push_back(8'h22);
      xfer(b, v);
      in_valid = 1'b0;
      build_frame(8'h00, 2);
      for (int i = 2; i < FL; i++) begin
         xfer(b, v);
         chk_cnt++;
         if (b !== ef[i]) $display("FAIL partial_b%0d got %h want %h", i, b, ef[i]); else pass_cnt++;
      end
      chk_cnt++; if (fifo_level !== 4'd0) $display("FAIL partial_level got %0d want 0", fifo_level); else pass_cnt++;
   endtask

   task automatic test_overflow();
      logic [7:0] b;
      logic       v;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1; in_data = 8'(k + 1);
         chk_cnt++;
         if (in_ready !== (k < 8)) $display("FAIL ovf_in_ready_%0d got %b want %b", k, in_ready, (k < 8));
         else pass_cnt++;
         if (k < 8) model_q.push_back(8'(k + 1));
         step();
      end
      in_valid = 1'b0;
      chk_cnt++; if (fifo_level !== 4'd8) $display("FAIL ovf_level got %0d want 8", fifo_level); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL ovf_full got %b want 0", in_ready); else pass_cnt++;
      chk_cnt++; if (data_out !== 8'hA5) $display("FAIL ovf_hold got %h want a5", data_out); else pass_cnt++;
      for (int f = 0; f < 3; f++) begin
         build_frame(8'(f), (f < 2) ? 4 : 0);
         for (int i = 0; i < FL; i++) begin
            xfer(b, v);
            chk_cnt++;
            if (b !== ef[i]) $display("FAIL ovf_f%0d_b%0d got %h want %h", f, i, b, ef[i]); else pass_cnt++;
         end
      end
      chk_cnt++; if (fifo_level !== 4'd0) $display("FAIL ovf_drain got %0d want 0", fifo_level); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      logic [7:0] prev;
      logic       r;
      int         idx;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_data = 8'hAA + 8'(k * 17);
         model_q.push_back(in_data);
         step();
      end
      in_valid = 1'b0;
      stream.delete();
      for (int f = 0; f < 3; f++) begin
         build_frame(8'(f), (f == 0) ? 3 : 0);
         for (int i = 0; i < FL; i++) stream.push_back(ef[i]);
      end
      idx = 0;
      for (int c = 0; c < 4000 && idx < stream.size(); c++) begin
         r    = 1'($urandom_range(0, 1));
         prev = data_out;
         output_ready = r;
         step();
         chk_cnt++;
         if (r) begin
            if (prev !== stream[idx]) $display("FAIL bp_byte%0d got %h want %h", idx, prev, stream[idx]);
            else pass_cnt++;
            idx++;
         end else begin
            if (data_out !== prev) $display("FAIL bp_stall_c%0d got %h want %h", c, data_out, prev);
            else pass_cnt++;
         end
      end
      chk_cnt++;
      if (idx != stream.size()) $display("FAIL bp_timeout got %0d want %0d", idx, stream.size()); else pass_cnt++;
   endtask

   task automatic test_reset_mid_and_wrap();
      logic [7:0] b;
      logic       v;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_data = 8'h30 + 8'(k);
         step();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) xfer(b, v);
      chk_cnt++; if (fifo_level !== 4'd2) $display("FAIL mid_pre_level got %0d want 2", fifo_level); else pass_cnt++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_cnt++; if (fifo_level !== 4'd0) $display("FAIL mid_level got %0d want 0", fifo_level); else pass_cnt++;
      chk_cnt++; if (data_out_ready !== 1'b0) $display("FAIL mid_dor got %b want 0", data_out_ready); else pass_cnt++;
      step();
      build_frame(8'h00, 0);
      for (int i = 0; i < 4; i++) begin
         xfer(b, v);
         chk_cnt++;
         if (b !== ef[i] || v !== 1'b1) $display("FAIL mid_b%0d got %h/%b want %h/1", i, b, v, ef[i]); else pass_cnt++;
      end
      chk_cnt++; if (seq_num !== 8'h00) $display("FAIL mid_seq got %h want 00", seq_num); else pass_cnt++;
      for (int i = 4; i < FL; i++) xfer(b, v);
      for (int f = 1; f < 255; f++)
         for (int i = 0; i < FL; i++) xfer(b, v);
      xfer(b, v); xfer(b, v);
      chk_cnt++; if (data_out !== 8'hFF) $display("FAIL wrap_ff_byte got %h want ff", data_out); else pass_cnt++;
      chk_cnt++; if (seq_num !== 8'hFF) $display("FAIL wrap_ff_seq got %h want ff", seq_num); else pass_cnt++;
      for (int i = 2; i < FL; i++) xfer(b, v);
      xfer(b, v); xfer(b, v);
      chk_cnt++; if (data_out !== 8'h00) $display("FAIL wrap_00_byte got %h want 00", data_out); else pass_cnt++;
      chk_cnt++; if (seq_num !== 8'h00) $display("FAIL wrap_00_seq got %h want 00", seq_num); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_empty();
      test_partial();
      test_overflow();
      test_backpressure();
      test_reset_mid_and_wrap();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
